adder_cla_pipe: RTL
===================

Name: adder_cla_pipe

Overview:
Parametrised, pipelined successor to the 32-bit combinational carry-lookahead adder. The operand width is split into NSEG equal segments. Each segment is a 4-bit-group CLA, and the inter-segment carry is registered, so one segment resolves per cycle. Adds add/subtract mode, signed-overflow flag and valid/ready flow control. Sits in datapaths needing NBIT>=32 at full clock rate.

Parameters:
NBIT, 32, operand/result width; must be a multiple of NSEG; NBIT/NSEG must be a multiple of 4.
NSEG, 4, pipeline segments (1..8); latency in cycles = NSEG.

Ports:
i_clk  input  1  clock, rising edge.
i_rstn  input  1  synchronous reset, active-low.
i_vld  input  1  input operands valid.
o_rdy  output  1  block can accept input this cycle.
i_a  input  NBIT  operand A.
i_b  input  NBIT  operand B.
i_c  input  1  carry-in (add) / borrow-in (sub).
i_sub  input  1  0: add, 1: subtract.
o_vld  output  1  result valid.
i_rdy  input  1  downstream accepts result.
o_s  output  NBIT  sum/difference.
o_c  output  1  raw carry-out of MSB segment.
o_ov  output  1  signed two's-complement overflow.

Behaviour:
- Clock/reset: one clock i_clk; reset i_rstn is synchronous, active-low; sampled on rising i_clk only.
- Reset: all stage valid bits, o_vld, o_s, o_c, o_ov and carry registers go to 0. o_rdy=1 in the first cycle after reset deasserts. In-flight data is discarded.
- Arithmetic:
  - Add: {o_c,o_s} = i_a + i_b + i_c.
  - Sub: {o_c,o_s} = i_a + ~i_b + ~i_c, i.e. i_a - i_b - i_c; o_c=1 means no borrow.
  - o_ov = (a[MSB]==b'[MSB]) & (s[MSB]!=a[MSB]), where b' is the post-inversion operand.
- Pipeline: stage k (0..NSEG-1) adds segment k bits [(k+1)W-1:kW], W=NBIT/NSEG, using the registered carry from stage k-1 (stage 0 uses i_c^i_sub).
  - Operand segments above k travel through skew registers.
  - Result segments below k travel through deskew registers.
  - All segments of one transaction emerge together.
- Within a segment: 4-bit lookahead groups, group P/G combined into the group carry chain. No ripple across more than one group level.
- Handshake:
  - Global stall: en = ~o_vld | i_rdy; o_rdy = en.
  - Input accepted when i_vld & o_rdy.
  - When en=0, every pipeline register (data and valid) holds.
  - Bubbles are not compressed.
- Latency: a transaction accepted in cycle t presents o_vld=1 in cycle t+NSEG if no stall; each stall cycle adds one.
- Throughput: one result per cycle with i_vld=1 and i_rdy=1 continuously.
- o_s/o_c/o_ov stay stable while o_vld=1 and i_rdy=0. Values when o_vld=0 are don't-care but must not be X after reset.
- Simultaneous accept and output: legal; no extra bubble.
- i_sub and i_c are captured with the operands and travel with the transaction; mixed add/sub streams are legal back-to-back.
- NSEG=1 degenerates to a registered single-stage CLA with latency 1.

Optional Feature:
- Macro: ADDER_CLA_PIPE_SAT_EN.
- Defined: when o_ov=1, o_s saturates to signed max (0x7FFF_FFFF for NBIT=32) if A is non-negative, else signed min (0x8000_0000). o_ov is still reported; o_c is unchanged raw carry.
- Undefined: o_s is the wrapped result; no saturation logic is instantiated.

Test Plan (NBIT=32, NSEG=4):
1. Reset, then single add 0x0000_FFFF + 0x0000_0001, i_c=0 -> o_vld exactly 4 cycles after accept; o_s=0x0001_0000, o_c=0, o_ov=0 (carry crosses segment boundary).
2. Add 0xFFFF_FFFF + 0x0000_0000, i_c=1 -> o_s=0x0000_0000, o_c=1, o_ov=0 (carry ripples through all 4 stages).
3. Sub 0x8000_0000 - 0x0000_0001, i_c=0 -> o_s=0x7FFF_FFFF, o_ov=1, o_c=1; with ADDER_CLA_PIPE_SAT_EN -> o_s=0x8000_0000.
4. 20 back-to-back random add/sub vectors with i_rdy=1 -> 20 consecutive o_vld cycles, results match the golden model in order.
5. Stream with i_rdy held 0 for 3 cycles mid-stream -> o_rdy=0 in those cycles, o_s held stable, no loss or duplication.
6. Assert i_rstn=0 for one cycle with 3 transactions in flight -> o_vld=0 next cycle, no stale result ever appears, next accepted vector returns correctly after 4 cycles.

Source files
------------

// File: rtl/adder_cla_pipe.sv
// adder_cla_pipe: pipelined carry-lookahead adder/subtractor with valid/ready flow control.
//
// The NBIT operands are cut into NSEG segments of W = NBIT/NSEG bits. Stage k
// resolves segment k with a 4-bit-group CLA using the registered carry from
// stage k-1. Unresolved operand bits ride along in skew registers, and resolved
// sum bits ride along in deskew registers, so every segment of a transaction
// reaches the output together after NSEG cycles.
//
// Handshake (valid/ready):
//   en    = ~o_vld | i_rdy    (global advance enable for every pipeline register)
//   o_rdy = en                (input accepted on a rising edge when i_vld & o_rdy)
//   Output transfer happens on a rising edge when o_vld & i_rdy. With en low,
//   every register (data and valid) holds, so o_s/o_c/o_ov stay stable while
//   o_vld=1 and i_rdy=0. Bubbles travel through and are not squeezed out.
//
// Optional build macro ADDER_CLA_PIPE_SAT_EN: on signed overflow, o_s saturates
// to signed max (A non-negative) or signed min (A negative). o_ov and the raw
// o_c carry are reported either way. Without the macro, o_s wraps.

module adder_cla_pipe #(
  parameter int NBIT = 32,
  parameter int NSEG = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_vld,
  output logic            o_rdy,
  input  logic [NBIT-1:0] i_a,
  input  logic [NBIT-1:0] i_b,
  input  logic            i_c,
  input  logic            i_sub,
  output logic            o_vld,
  input  logic            i_rdy,
  output logic [NBIT-1:0] o_s,
  output logic            o_c,
  output logic            o_ov
);

  localparam int W    = NBIT / NSEG;
  localparam int NGRP = W / 4;
  localparam int MSB  = NBIT - 1;

`ifdef ADDER_CLA_PIPE_SAT_EN
  localparam logic [NBIT-1:0] SMAX = {1'b0, {(NBIT-1){1'b1}}};
  localparam logic [NBIT-1:0] SMIN = {1'b1, {(NBIT-1){1'b0}}};
`endif

  // One segment: 4-bit lookahead groups feeding a group-level carry chain.
  // Returns {carry_out, sum}.
  function automatic logic [W:0] cla_seg(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         cin
  );
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic [3:0]   gq;
    logic [3:0]   pq;
    logic         cg;
    logic         grp_g;
    logic         grp_p;
    g     = a & b;
    p     = a ^ b;
    c     = '0;
    cg    = cin;
    gq    = '0;
    pq    = '0;
    grp_g = 1'b0;
    grp_p = 1'b0;
    for (int j = 0; j < NGRP; j++) begin
      gq = g[4*j +: 4];
      pq = p[4*j +: 4];
      c[4*j +: 4] = {
        gq[2] | (pq[2] & gq[1]) | (pq[2] & pq[1] & gq[0]) | (pq[2] & pq[1] & pq[0] & cg),
        gq[1] | (pq[1] & gq[0]) | (pq[1] & pq[0] & cg),
        gq[0] | (pq[0] & cg),
        cg
      };
      grp_g = gq[3] | (pq[3] & gq[2]) | (pq[3] & pq[2] & gq[1]) | (pq[3] & pq[2] & pq[1] & gq[0]);
      grp_p = &pq;
      cg    = grp_g | (grp_p & cg);
    end
    c[W] = cg;
    return {c[W], p ^ c[W-1:0]};
  endfunction

  logic            en;

  // Pipeline registers, index k = output of stage k.
  logic [NBIT-1:0] x_q [NSEG];   // sum bits for segments <= k, operand A above
  logic [NBIT-1:0] b_q [NSEG];   // post-inversion operand B (upper segments consumed later)
  logic [NSEG-1:0] c_q;          // carry out of segment k
  logic [NSEG-1:0] vld_q;
  logic            ov_q;

  // Stage inputs and next-state values.
  logic [NBIT-1:0] x_i [NSEG];
  logic [NBIT-1:0] b_i [NSEG];
  logic [NBIT-1:0] x_d [NSEG];
  logic [NSEG-1:0] c_i;
  logic [NSEG-1:0] v_i;
  logic [W:0]      seg [NSEG];
  logic            ov_d;

  assign en    = ~vld_q[NSEG-1] | i_rdy;
  assign o_rdy = en;

  // Stage inputs: stage 0 takes the ports, later stages take the previous stage's registers.
  always_comb begin
    x_i[0] = i_a;
    b_i[0] = i_sub ? ~i_b : i_b;
    c_i[0] = i_c ^ i_sub;
    v_i[0] = i_vld & en;
    for (int k = 1; k < NSEG; k++) begin
      x_i[k] = x_q[k-1];
      b_i[k] = b_q[k-1];
      c_i[k] = c_q[k-1];
      v_i[k] = vld_q[k-1];
    end
  end

  // Each stage resolves its own segment; the last stage also forms overflow (and saturation).
  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      seg[k] = cla_seg(x_i[k][k*W +: W], b_i[k][k*W +: W], c_i[k]);
      x_d[k] = x_i[k];
      x_d[k][k*W +: W] = seg[k][W-1:0];
    end
    ov_d = (x_i[NSEG-1][MSB] == b_i[NSEG-1][MSB]) &
           (seg[NSEG-1][W-1] != x_i[NSEG-1][MSB]);
`ifdef ADDER_CLA_PIPE_SAT_EN
    if (ov_d) begin
      x_d[NSEG-1] = x_i[NSEG-1][MSB] ? SMIN : SMAX;
    end
`endif
  end

  // Pipeline advance: everything moves together on en, everything holds otherwise.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      for (int k = 0; k < NSEG; k++) begin
        x_q[k] <= '0;
        b_q[k] <= '0;
      end
      c_q   <= '0;
      vld_q <= '0;
      ov_q  <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < NSEG; k++) begin
        x_q[k] <= x_d[k];
        b_q[k] <= b_i[k];
        c_q[k] <= seg[k][W];
      end
      vld_q <= v_i;
      ov_q  <= ov_d;
    end
  end

  assign o_vld = vld_q[NSEG-1];
  assign o_s   = x_q[NSEG-1];
  assign o_c   = c_q[NSEG-1];
  assign o_ov  = ov_q;

endmodule
